// File: rtl/echo_pkg.sv
// echo_pkg: shared state encoding, default ADC/DAC offsets and the saturation helper.
package echo_pkg;

    typedef enum logic [2:0] {CLEAR, IDLE, READ, CALC, WRITE} state_t;

    localparam int ADC_OFFSET_DEF = 'h181;
    localparam int DAC_OFFSET_DEF = 'h200;

    function automatic int sat(input int v, input int w);
        int hi, lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        return v > hi ? hi : v < lo ? lo : v;
    endfunction

endpackage

// File: rtl/echo_ram.sv
// echo_ram: simple dual-port delay RAM, one write port and one registered read port.
module echo_ram #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 13
) (
    input  logic              sysclk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge sysclk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/echo_delay_line.sv
// echo_delay_line: feedback echo processor, offset-binary ADC in -> delay RAM -> offset-binary DAC out.
// Define ECHO_SAT_EN to clamp the echo sum to DATA_W bits instead of wrapping it.
module echo_delay_line
    import echo_pkg::*;
#(
    parameter int DATA_W     = 10,
    parameter int ADDR_W     = 13,
    parameter int DLY_W      = 9,
    parameter int DLY_SHIFT  = 4,
    parameter int GAIN_W     = 8,
    parameter int ADC_OFFSET = ADC_OFFSET_DEF,
    parameter int DAC_OFFSET = DAC_OFFSET_DEF
) (
    input  logic              sysclk,
    input  logic              rstn,
    input  logic              valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DLY_W-1:0]  rdelay,
    input  logic [GAIN_W-1:0] fb_gain,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int PW = DATA_W + GAIN_W + 1;

    state_t state, state_nx;
    logic valid_q, stb_q, we;
    logic [DATA_W-1:0] din_q, x, q, y, y_q, wdata;
    logic [ADDR_W-1:0] d, wr_ptr;
    logic [GAIN_W-1:0] g;
    logic signed [PW-1:0] prod;
    logic signed [DATA_W:0] xs, e, y_wide;

    echo_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .sysclk(sysclk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (wr_ptr - d),
        .rdata (q)
    );

    always_comb begin
        state_nx = state;
        case (state)
            CLEAR:   state_nx = (wr_ptr == '1) ? IDLE : CLEAR;
            IDLE:    state_nx = stb_q ? READ : IDLE;
            READ:    state_nx = CALC;
            CALC:    state_nx = WRITE;
            default: state_nx = IDLE;
        endcase
        busy = state != IDLE;
        we = state == CLEAR || state == WRITE;
        wdata = state == CLEAR ? '0 : y_q;
        prod = PW'($signed(q)) * PW'($signed({1'b0, g}));
        e = (DATA_W+1)'(prod >>> GAIN_W);
        xs = {x[DATA_W-1], x};
        y_wide = d == '0 ? xs : xs - e;
`ifdef ECHO_SAT_EN
        y = DATA_W'(sat(int'(y_wide), DATA_W));
`else
        y = DATA_W'(int'(y_wide));
`endif
    end

    // The strobe is registered so the FSM sees a clean one-cycle pulse; data_in is captured with it.
    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            state     <= CLEAR;
            wr_ptr    <= '0;
            valid_q   <= 1'b0;
            stb_q     <= 1'b0;
            din_q     <= '0;
            x         <= '0;
            d         <= '0;
            g         <= '0;
            y_q       <= '0;
            data_out  <= DATA_W'(DAC_OFFSET);
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state   <= state_nx;
            valid_q <= valid;
            stb_q   <= valid & ~valid_q;
            if (valid & ~valid_q) din_q <= data_in;
            if (state == IDLE && stb_q) begin
                x <= din_q - DATA_W'(ADC_OFFSET);
                d <= ADDR_W'(rdelay) << DLY_SHIFT;
                g <= fb_gain;
            end
            if (stb_q && (state == READ || state == CALC || state == WRITE)) overrun <= 1'b1;
            if (state == CLEAR || state == WRITE) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (state == CALC) y_q <= y;
            out_valid <= state == WRITE;
            if (state == WRITE) data_out <= y_q + DATA_W'(DAC_OFFSET);
        end
    end

endmodule

// File: tb/tb_echo_delay_line.sv
// tb_echo_delay_line: table vectors and hand sequences against a behavioural echo model via a scoreboard.
module tb_echo_delay_line;

    localparam int DEPTH = 256;

    logic       sysclk = 1'b0;
    logic       rstn = 1'b0;
    logic       valid = 1'b0;
    logic [9:0] data_in = '0;
    logic [3:0] rdelay = '0;
    logic [7:0] fb_gain = '0;
    logic [9:0] data_out;
    logic       out_valid, busy, overrun;

    echo_delay_line #(
        .DATA_W(10), .ADDR_W(8), .DLY_W(4), .DLY_SHIFT(4), .GAIN_W(8)
    ) dut (
        .sysclk   (sysclk),
        .rstn     (rstn),
        .valid    (valid),
        .data_in  (data_in),
        .rdelay   (rdelay),
        .fb_gain  (fb_gain),
        .data_out (data_out),
        .out_valid(out_valid),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic [9:0] din;
        logic [3:0] rd;
        logic [7:0] g;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[20];
    logic [9:0] sb[$];
    int compared = 0, mismatched = 0;
    int mem_m[DEPTH];
    int ptr_m = 0;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        foreach (mem_m[i]) mem_m[i] = 0;
        ptr_m = 0;
    endtask

    task automatic model_step(input logic [9:0] din, input logic [3:0] rd, input logic [7:0] gg,
                              output logic [9:0] o);
        int x, q, y, dd;
        x = ((int'(din) - 'h181) % 1024 + 1024) % 1024;
        if (x >= 512) x -= 1024;
        dd = int'(rd) * 16;
        q = mem_m[(ptr_m - dd + DEPTH) % DEPTH];
        y = (dd == 0) ? x : x - ((q * int'(gg)) >>> 8);
`ifdef ECHO_SAT_EN
        y = y > 511 ? 511 : y < -512 ? -512 : y;
`else
        y = (y % 1024 + 1024) % 1024;
        if (y >= 512) y -= 1024;
`endif
        mem_m[ptr_m] = y;
        ptr_m = (ptr_m + 1) % DEPTH;
        o = 10'(y + 512);
    endtask

    // One sample: strobe, queue the expected output, and check out_valid lands exactly 4 edges later.
    task automatic send(input logic [9:0] din, input logic [3:0] rd, input logic [7:0] gg,
                        input bit use_exp, input logic [9:0] exp);
        logic [9:0] m;
        int lat = 0;
        model_step(din, rd, gg, m);
        sb.push_back(use_exp ? exp : m);
        @(negedge sysclk);
        data_in = din;
        rdelay = rd;
        fb_gain = gg;
        valid = 1'b1;
        @(negedge sysclk);
        valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge sysclk);
            #1;
            if (out_valid) lat = k;
        end
        check("latency", lat, 4);
    endtask

    task automatic wait_clear(input string name);
        int n = 0;
        do begin
            @(posedge sysclk);
            #1;
            n++;
        end while (busy && n < 2000);
        check(name, n, DEPTH);
    endtask

    always @(negedge sysclk) begin
        if (rstn && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check("data_out", data_out, sb.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] dummy;
        int pulses;
        tbl[0] = '{10'h281, 4'd1, 8'h80, 10'h300};
        for (int i = 1; i <= 15; i++) tbl[i] = '{10'h181, 4'd1, 8'h80, 10'h200};
        tbl[16] = '{10'h181, 4'd1, 8'h80, 10'h180};
        tbl[17] = '{10'h181, 4'd1, 8'h80, 10'h200};
        tbl[18] = '{10'h181, 4'd0, 8'h80, 10'h200};
        tbl[19] = '{10'h281, 4'd0, 8'h80, 10'h300};

        model_reset();
        #12;
        check("rst_data_out", data_out, 'h200);
        check("rst_busy", busy, 1);
        check("rst_overrun", overrun, 0);
        check("rst_out_valid", out_valid, 0);
        @(negedge sysclk);
        rstn = 1'b1;
        wait_clear("clear_cycles");
        check("idle_overrun", overrun, 0);

        foreach (tbl[i]) send(tbl[i].din, tbl[i].rd, tbl[i].g, 1'b1, tbl[i].exp);

        // Build +511 history at gain 0, then hit it with full gain and a strongly negative input.
        send(10'h380, 4'd1, 8'h00, 1'b0, 10'h0);
        for (int i = 0; i < 15; i++) send(10'h181, 4'd1, 8'h00, 1'b0, 10'h0);
`ifdef ECHO_SAT_EN
        send(10'h001, 4'd1, 8'hFF, 1'b1, 10'h000);
`else
        send(10'h001, 4'd1, 8'hFF, 1'b1, 10'h283);
`endif

        check("pre_overrun", overrun, 0);
        model_step(10'h2A0, 4'd2, 8'h40, dummy);
        sb.push_back(dummy);
        @(negedge sysclk);
        data_in = 10'h2A0;
        rdelay = 4'd2;
        fb_gain = 8'h40;
        valid = 1'b1;
        @(negedge sysclk);
        valid = 1'b0;
        @(negedge sysclk);
        valid = 1'b1;
        @(negedge sysclk);
        valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sysclk);
            if (out_valid) pulses++;
        end
        check("overrun_pulses", pulses, 1);
        check("overrun_set", overrun, 1);
        send(10'h181, 4'd0, 8'h00, 1'b0, 10'h0);
        check("overrun_sticky", overrun, 1);

        @(negedge sysclk);
        data_in = 10'h3F0;
        rdelay = 4'd0;
        valid = 1'b1;
        @(negedge sysclk);
        valid = 1'b0;
        @(posedge sysclk);
        @(posedge sysclk);
        #1;
        rstn = 1'b0;
        #1;
        check("midrst_data_out", data_out, 'h200);
        check("midrst_busy", busy, 1);
        check("midrst_overrun", overrun, 0);
        repeat (6) begin
            @(negedge sysclk);
            check("midrst_no_pulse", out_valid, 0);
        end
        model_reset();
        rstn = 1'b1;
        wait_clear("reclear_cycles");

        for (int i = 0; i < DEPTH + 5; i++)
            send(10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                 1'b0, 10'h0);
        send(10'h181, 4'd0, 8'h00, 1'b0, 10'h0);
        repeat (4) @(negedge sysclk);
        check("scoreboard_drained", sb.size(), 0);
        check("final_overrun", overrun, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
